// File: rtl/gf2_poly_div_seq.sv
// Bit-serial GF(2) polynomial divider: a = q*b ^ r, one quotient bit per clock.
// Define GF2DIV_REM_ONLY_EN for the reducer-only build (q tied to zero, no quotient register).
module gf2_poly_div_seq #(
  parameter int unsigned N = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-2:0]   a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-2:0]   q,
  output logic [N-2:0]     r,
  output logic             div_by_zero
);

  localparam int unsigned AW = 2 * N - 1;
  localparam int unsigned CW = $clog2(2 * N);

  typedef enum logic [1:0] {StIdle, StNorm, StDiv, StDone} state_e;

  state_e        state_q;
  logic [AW-1:0] rem_q;   // working remainder, starts as the dividend
  logic [AW-1:0] dv_q;    // b * x^k for the current quotient position k
  logic [AW-1:0] mask_q;  // one-hot at bit k + deg b, the leading bit of dv_q
  logic [CW-1:0] cnt_q;   // NORM: N + shifts so far; DIV: iterations left
  logic          zero_q;
  logic          hit;

`ifdef GF2DIV_REM_ONLY_EN
  assign q = '0;
`else
  logic [AW-1:0] qw_q;
`endif

  assign in_ready = (state_q == StIdle);
  assign hit      = |(rem_q & mask_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      dv_q        <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      out_valid   <= 1'b0;
      r           <= '0;
      div_by_zero <= 1'b0;
`ifndef GF2DIV_REM_ONLY_EN
      qw_q        <= '0;
      q           <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            rem_q  <= a;
            dv_q   <= {b, {(N - 1){1'b0}}};
            mask_q <= {1'b1, {(AW - 1){1'b0}}};
            zero_q <= (b == '0);
`ifndef GF2DIV_REM_ONLY_EN
            qw_q   <= '0;
`endif
            if (b == '0) begin
              // Zero iterations: the DIV finalise edge reports the divide-by-zero.
              cnt_q   <= '0;
              state_q <= StDiv;
            end else if (b[N-1]) begin
              cnt_q   <= CW'(N);
              state_q <= StDiv;
            end else begin
              cnt_q   <= CW'(N);
              state_q <= StNorm;
            end
          end
        end

        StNorm: begin
          dv_q  <= dv_q << 1;
          cnt_q <= cnt_q + CW'(1);
          if (dv_q[AW-2]) begin
            state_q <= StDiv;
          end
        end

        StDiv: begin
          if (cnt_q != '0) begin
            if (hit) begin
              rem_q <= rem_q ^ dv_q;
            end
`ifndef GF2DIV_REM_ONLY_EN
            qw_q  <= {qw_q[AW-2:0], hit};
`endif
            dv_q   <= dv_q >> 1;
            mask_q <= mask_q >> 1;
            cnt_q  <= cnt_q - CW'(1);
          end else begin
            out_valid   <= 1'b1;
            div_by_zero <= zero_q;
            r           <= zero_q ? '0 : rem_q[N-2:0];
`ifndef GF2DIV_REM_ONLY_EN
            q           <= zero_q ? '0 : qw_q;
`endif
            state_q     <= StDone;
          end
        end

        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
